sap1_out_display: RTL and testbench
===================================

# sap1_out_display

Output-display stage downstream of the SAP-1 core. Captures each value written to the core's 8-bit output register and converts it to three BCD digits with a sequential double-dabble converter, one bit per cycle. It then time-multiplexes the digits onto a single 7-segment bus for the board's 3-digit display. It is the only consumer of the core's output-register value and its load strobe.

## Interface
Parameters:
- SCAN_DIV, default 4: clock cycles each digit stays selected; legal range 1..65535.

Ports:
- clk  input  1  system clock, all state on the rising edge.
- rst  input  1  synchronous, active-high reset.
- out_val  input  8  SAP-1 output-register value, unsigned.
- out_load  input  1  one-cycle strobe, high in the cycle the core loads its output register.
- busy  output  1  high while a conversion is in progress.
- bcd  output  12  last completed result: [11:8] hundreds, [7:4] tens, [3:0] ones.
- dig_sel  output  3  one-hot digit enable, active-high: 001 ones, 010 tens, 100 hundreds.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high.

## Operation
- Reset: state IDLE, busy=0, bcd=12'h000, pending flag clear, scan counter 0, dig_sel=001. seg therefore shows 7'h3F ("0").
- FSM has two states: IDLE and CONV.
  - IDLE with out_load=1: load a 20-bit shift register as {12'h000, out_val}, set the bit counter to 0, go to CONV, busy=1.
  - CONV, each cycle: for each of the three BCD nibbles in [19:8], add 3 if the nibble is >= 5; then shift the whole register left by 1; increment the counter.
  - On the 8th CONV edge: write the adjusted and shifted [19:8] to bcd.
    - If the pending flag is set, or out_load is high on this edge: reload from the pending/strobed value, stay in CONV, keep busy=1.
    - Otherwise go to IDLE, busy=0.
- out_load while in CONV, other than on the completion edge: store out_val in a one-deep pending register and set the pending flag.
  - A later strobe overwrites the stored value; the latest value wins.
  - On the completion edge, a same-edge out_load value takes precedence over the stored pending value.
- bcd changes only on a completion edge, never mid-conversion.
- Widths: nibble add-3 is 4-bit with no carry out. Inputs 0..255 give valid BCD, with hundreds at most 2.
- Scanner runs continuously, independent of the FSM.
  - Cycle counter 0..SCAN_DIV-1. On the edge where the counter equals SCAN_DIV-1, it wraps to 0 and dig_sel advances 001 -> 010 -> 100 -> 001.
- seg is combinational from the selected nibble of the registered bcd.
  - Digit codes: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
- Leading-zero blanking, with blank = 7'h00:
  - Hundreds digit blank when hundreds=0.
  - Tens digit blank when hundreds=0 and tens=0.
  - Ones digit never blank.

## Timing
- out_load sampled high at edge N while IDLE: busy=1 after edge N; bcd holds the new value and busy=0 after edge N+8. Latency is 8 cycles, busy high for exactly 8 cycles.
- Back-to-back conversions: no idle bubble; each further conversion takes 8 more cycles.
- Maximum sustained rate: one captured value per 8 cycles. Strobes arriving faster collapse into the latest value.
- rst high at any edge, including mid-conversion: all state returns to reset values on that edge. The partial result and pending value are discarded, and bcd returns to 0.
- out_load in the same cycle as rst: ignored.
- dig_sel changes only on scan-wrap edges. Each one-hot code is held exactly SCAN_DIV cycles; a full 3-digit frame takes 3*SCAN_DIV cycles.
- A bcd update mid-slot changes seg immediately for the currently selected digit; dig_sel is unaffected.

## Test plan
- Reset: hold rst 3 cycles -> busy=0, bcd=000, dig_sel=001, seg=3F. After release, dig_sel reaches 010 after 4 edges (SCAN_DIV=4) and seg=00 (blanked).
- Single conversion: out_val=255 with out_load at edge N -> busy high for edges N+1..N+8, bcd=12'h255 after N+8. Scan frame shows seg 6D on ones, 6D on tens, 5B on hundreds.
- Blanking: out_val=7 -> bcd=007, seg 07 on ones, 00 on tens and hundreds. out_val=40 -> bcd=040, ones 3F, tens 66, hundreds 00.
- Collision: load 200 at edge N, strobe 13 at N+3 and 99 at N+5 -> bcd=200 after N+8, busy stays 1, bcd=099 after N+16, busy=0 after N+16. Value 13 is never shown.
- Completion-edge strobe: load 128 at N, pending 50 set at N+2, strobe 77 exactly at N+8 -> bcd=128 at N+8, then bcd=077 at N+16.
- Reset mid-conversion: load 255, assert rst at N+4 -> bcd=000, busy=0 after N+4, no update at N+8. SCAN_DIV=1 variant: dig_sel advances every cycle.

Source files
------------

// File: rtl/sap1_out_display_if.sv
`default_nettype none
// ============================================================================
// Module      : sap1_out_display_if
// Description : Output-register capture bus and display outputs for the SAP-1
//               output-display stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface sap1_out_display_if;
    logic [7:0]  out_val;
    logic        out_load;
    logic        busy;
    logic [11:0] bcd;
    logic [2:0]  dig_sel;
    logic [6:0]  seg;

    modport master (
        output out_val,
        output out_load,
        input  busy,
        input  bcd,
        input  dig_sel,
        input  seg
    );

    modport slave (
        input  out_val,
        input  out_load,
        output busy,
        output bcd,
        output dig_sel,
        output seg
    );
endinterface
`default_nettype wire

// File: rtl/sap1_out_display.sv
`default_nettype none
// ============================================================================
// Module      : sap1_out_display
// Description : Captures SAP-1 output values, converts them to BCD with a
//               bit-serial double-dabble, and scans three 7-segment digits.
// Revision    : 1.0 - initial release
// ============================================================================
module sap1_out_display #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    sap1_out_display_if.slave bus
);

    localparam logic [0:0]  S_IDLE      = 1'b0;
    localparam logic [0:0]  S_CONV      = 1'b1;
    localparam logic [15:0] C_SCAN_LAST = 16'(SCAN_DIV - 1);

    logic [0:0]  state_q,    state_d;
    logic [19:0] shreg_q,    shreg_d;
    logic [2:0]  cnt_q,      cnt_d;
    logic [11:0] bcd_q,      bcd_d;
    logic        pend_q,     pend_d;
    logic [7:0]  pend_val_q, pend_val_d;
    logic [15:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]  dig_sel_q,  dig_sel_d;

    logic [19:0] w_adj;
    logic [19:0] w_shifted;
    logic [3:0]  w_nib;
    logic        w_blank;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            scan_cnt_q <= '0;
            dig_sel_q  <= 3'b001;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            scan_cnt_q <= scan_cnt_d;
            dig_sel_q  <= dig_sel_d;
        end
    end

    assign w_adj     = {add3(shreg_q[19:16]), add3(shreg_q[15:12]),
                        add3(shreg_q[11:8]), shreg_q[7:0]};
    assign w_shifted = {w_adj[18:0], 1'b0};

    // Next-state and datapath
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        case (state_q)
            S_IDLE: begin
                if (bus.out_load) begin
                    state_d = S_CONV;
                    shreg_d = {12'h000, bus.out_val};
                    cnt_d   = 3'd0;
                end
            end
            S_CONV: begin
                shreg_d = w_shifted;
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    bcd_d = w_shifted[19:8];
                    // A same-edge strobe is newer than anything parked in pending
                    if (bus.out_load) begin
                        shreg_d = {12'h000, bus.out_val};
                        cnt_d   = 3'd0;
                        pend_d  = 1'b0;
                    end else if (pend_q) begin
                        shreg_d = {12'h000, pend_val_q};
                        cnt_d   = 3'd0;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (bus.out_load) begin
                    pend_d     = 1'b1;
                    pend_val_d = bus.out_val;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Free-running digit scanner
    always_comb begin
        scan_cnt_d = scan_cnt_q + 16'd1;
        dig_sel_d  = dig_sel_q;
        if (scan_cnt_q == C_SCAN_LAST) begin
            scan_cnt_d = 16'd0;
            dig_sel_d  = {dig_sel_q[1:0], dig_sel_q[2]};
        end
    end

    // Outputs
    always_comb begin
        w_nib   = bcd_q[3:0];
        w_blank = 1'b0;
        case (dig_sel_q)
            3'b010: begin
                w_nib   = bcd_q[7:4];
                w_blank = (bcd_q[11:4] == 8'h00);
            end
            3'b100: begin
                w_nib   = bcd_q[11:8];
                w_blank = (bcd_q[11:8] == 4'h0);
            end
            default: w_nib = bcd_q[3:0];
        endcase

        bus.busy    = (state_q == S_CONV);
        bus.bcd     = bcd_q;
        bus.dig_sel = dig_sel_q;
        case (w_nib)
            4'd0:    bus.seg = 7'h3F;
            4'd1:    bus.seg = 7'h06;
            4'd2:    bus.seg = 7'h5B;
            4'd3:    bus.seg = 7'h4F;
            4'd4:    bus.seg = 7'h66;
            4'd5:    bus.seg = 7'h6D;
            4'd6:    bus.seg = 7'h7D;
            4'd7:    bus.seg = 7'h07;
            4'd8:    bus.seg = 7'h7F;
            4'd9:    bus.seg = 7'h6F;
            default: bus.seg = 7'h00;
        endcase
        if (w_blank) begin
            bus.seg = 7'h00;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sap1_out_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_sap1_out_display
// Description : Self-checking bench for sap1_out_display (SCAN_DIV 4 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sap1_out_display;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sap1_out_display_if ifc4();
    sap1_out_display_if ifc1();
    assign ifc1.out_val  = ifc4.out_val;
    assign ifc1.out_load = ifc4.out_load;

    sap1_out_display #(.SCAN_DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(ifc4));
    sap1_out_display #(.SCAN_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1));

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: value-level, not bit-level
    int m_busy, m_left, m_val, m_pend, m_pv, m_bcd, m_ticks;

    logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct {
        logic [7:0]  val;
        logic [11:0] b;
        logic [6:0]  so;
        logic [6:0]  st;
        logic [6:0]  sh;
    } vec_t;

    vec_t tbl [6];

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(input int idx, input int v);
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        if (idx == 2) return (h == 0) ? 7'h00 : seg_tab[h];
        if (idx == 1) return (h == 0 && t == 0) ? 7'h00 : seg_tab[t];
        return seg_tab[o];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_edge(input logic ld, input logic [7:0] v, input logic r);
        if (r) begin
            m_busy = 0; m_left = 0; m_pend = 0; m_bcd = 0; m_ticks = 0;
        end else begin
            m_ticks++;
            if (m_busy == 0) begin
                if (ld) begin
                    m_busy = 1; m_val = int'(v); m_left = 8;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_bcd = m_val;
                    if (ld) begin
                        m_val = int'(v); m_left = 8; m_pend = 0;
                    end else if (m_pend != 0) begin
                        m_val = m_pv; m_left = 8; m_pend = 0;
                    end else begin
                        m_busy = 0;
                    end
                end else if (ld) begin
                    m_pend = 1; m_pv = int'(v);
                end
            end
        end
    endtask

    task automatic check_all();
        int idx4, idx1;
        idx4 = (m_ticks / 4) % 3;
        idx1 = m_ticks % 3;
        chk("busy",         32'(ifc4.busy),    32'(m_busy));
        chk("bcd",          32'(ifc4.bcd),     32'(to_bcd(m_bcd)));
        chk("dig_sel",      32'(ifc4.dig_sel), 32'(1 << idx4));
        chk("seg",          32'(ifc4.seg),     32'(exp_seg(idx4, m_bcd)));
        chk("dig_sel_div1", 32'(ifc1.dig_sel), 32'(1 << idx1));
        chk("bcd_div1",     32'(ifc1.bcd),     32'(to_bcd(m_bcd)));
    endtask

    // Drive at negedge, model the edge, check 1 time unit after it
    task automatic step(input logic ld, input logic [7:0] v, input logic r);
        ifc4.out_load = ld;
        ifc4.out_val  = v;
        rst           = r;
        @(posedge clk);
        model_edge(ld, v, r);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        tbl[0] = '{8'd255, 12'h255, 7'h6D, 7'h6D, 7'h5B};
        tbl[1] = '{8'd7,   12'h007, 7'h07, 7'h00, 7'h00};
        tbl[2] = '{8'd40,  12'h040, 7'h3F, 7'h66, 7'h00};
        tbl[3] = '{8'd0,   12'h000, 7'h3F, 7'h00, 7'h00};
        tbl[4] = '{8'd100, 12'h100, 7'h3F, 7'h3F, 7'h06};
        tbl[5] = '{8'd203, 12'h203, 7'h4F, 7'h3F, 7'h5B};

        rst = 1'b1;
        ifc4.out_load = 1'b0;
        ifc4.out_val  = 8'h00;
        @(negedge clk);

        // Reset state, then first scan advance
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        chk("rst_busy",    32'(ifc4.busy),    32'd0);
        chk("rst_bcd",     32'(ifc4.bcd),     32'h000);
        chk("rst_dig_sel", 32'(ifc4.dig_sel), 32'b001);
        chk("rst_seg",     32'(ifc4.seg),     32'h3F);
        idle(4);
        chk("scan_tens_sel",   32'(ifc4.dig_sel), 32'b010);
        chk("scan_tens_blank", 32'(ifc4.seg),     32'h00);

        // Table of single conversions and their displayed frames
        for (int e = 0; e < 6; e++) begin
            step(1'b1, tbl[e].val, 1'b0);
            for (int i = 0; i < 7; i++) begin
                step(1'b0, 8'h00, 1'b0);
                chk("tbl_busy_mid", 32'(ifc4.busy), 32'd1);
            end
            step(1'b0, 8'h00, 1'b0);
            chk("tbl_bcd",  32'(ifc4.bcd),  32'(tbl[e].b));
            chk("tbl_busy", 32'(ifc4.busy), 32'd0);
            for (int k = 0; k < 12; k++) begin
                step(1'b0, 8'h00, 1'b0);
                case ((m_ticks / 4) % 3)
                    0:       chk("tbl_seg_ones", 32'(ifc4.seg), 32'(tbl[e].so));
                    1:       chk("tbl_seg_tens", 32'(ifc4.seg), 32'(tbl[e].st));
                    default: chk("tbl_seg_hund", 32'(ifc4.seg), 32'(tbl[e].sh));
                endcase
            end
        end

        // Collision: 13 overwritten by 99
        step(1'b1, 8'd200, 1'b0);
        idle(2);
        step(1'b1, 8'd13, 1'b0);
        idle(1);
        step(1'b1, 8'd99, 1'b0);
        idle(2);
        step(1'b0, 8'h00, 1'b0);
        chk("coll_bcd1",  32'(ifc4.bcd),  32'h200);
        chk("coll_busy1", 32'(ifc4.busy), 32'd1);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 8'h00, 1'b0);
            chk("coll_no_13", 32'(ifc4.bcd == 12'h013), 32'd0);
        end
        step(1'b0, 8'h00, 1'b0);
        chk("coll_bcd2",  32'(ifc4.bcd),  32'h099);
        chk("coll_busy2", 32'(ifc4.busy), 32'd0);

        // Completion-edge strobe beats pending
        step(1'b1, 8'd128, 1'b0);
        idle(1);
        step(1'b1, 8'd50, 1'b0);
        idle(5);
        step(1'b1, 8'd77, 1'b0);
        chk("cedge_bcd1", 32'(ifc4.bcd), 32'h128);
        idle(8);
        chk("cedge_bcd2", 32'(ifc4.bcd),  32'h077);
        chk("cedge_busy", 32'(ifc4.busy), 32'd0);

        // Reset mid-conversion
        step(1'b1, 8'd255, 1'b0);
        idle(3);
        step(1'b0, 8'h00, 1'b1);
        chk("midrst_bcd",  32'(ifc4.bcd),     32'h000);
        chk("midrst_busy", 32'(ifc4.busy),    32'd0);
        chk("midrst_sel1", 32'(ifc1.dig_sel), 32'b001);
        idle(4);
        chk("midrst_no_upd", 32'(ifc4.bcd),     32'h000);
        chk("div1_sel",      32'(ifc1.dig_sel), 32'b010);

        // Strobe coincident with reset is ignored
        step(1'b1, 8'd42, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        chk("rst_load_ignored", 32'(ifc4.busy), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) == 0, 8'($urandom), ($urandom % 97) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
